// File: rtl/udc_param.sv
// Parametrised up/down counter with programmable width and modulus, synchronous
// clamped load, wrap/saturate at the limits, terminal-count pulse and sticky overflow.
module udc_param #(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 64'd16,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             udc_clk,
    input  logic             udc_rst,
    input  logic             udc_en,
    input  logic             udc_up,
    input  logic             udc_load,
    input  logic [WIDTH-1:0] udc_din,
    input  logic             udc_clr_ovf,
    output logic [WIDTH-1:0] udc_out,
    output logic             udc_tc,
    output logic             udc_ovf
);

    // Limits are computed at 64 bits so MODULUS = 2^32 with WIDTH = 32 stays exact.
    localparam logic [63:0]      MOD_64  = 64'(MODULUS);
    localparam logic [63:0]      MAX_64  = MOD_64 - 64'd1;
    localparam logic [WIDTH-1:0] MAX_VAL = MAX_64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1'b1);

    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic [63:0]      din_64_s;
    logic             din_over_s;
    logic             limit_s;

    assign din_64_s   = {{(64-WIDTH){1'b0}}, udc_din};
    assign din_over_s = (din_64_s >= MOD_64);

    // Next-state: load beats count beats hold; a limit event sets tc and ovf.
    always_comb begin
        out_d   = out_q;
        limit_s = 1'b0;
        if (udc_load) begin
            if (din_over_s) begin
                out_d = MAX_VAL;
            end else begin
                out_d = udc_din;
            end
        end else if (udc_en) begin
            if (udc_up) begin
                if (out_q == MAX_VAL) begin
                    limit_s = 1'b1;
                    if (SATURATE) begin
                        out_d = out_q;
                    end else begin
                        out_d = ZERO;
                    end
                end else begin
                    out_d = out_q + ONE;
                end
            end else begin
                if (out_q == ZERO) begin
                    limit_s = 1'b1;
                    if (SATURATE) begin
                        out_d = out_q;
                    end else begin
                        out_d = MAX_VAL;
                    end
                end else begin
                    out_d = out_q - ONE;
                end
            end
        end else begin
            out_d = out_q;
        end
    end

    // Pulse and sticky flag; a coinciding set wins over clear.
    always_comb begin
        tc_d  = limit_s;
        ovf_d = ovf_q;
        if (limit_s) begin
            ovf_d = 1'b1;
        end else if (udc_clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge udc_clk or negedge udc_rst) begin
        if (!udc_rst) begin
            out_q <= ZERO;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign udc_out = out_q;
    assign udc_tc  = tc_q;
    assign udc_ovf = ovf_q;

endmodule

// File: tb/tb_udc_param.sv
// Scoreboard bench for udc_param: three instances (wrap M10, saturate M10, full-range W3 M8)
// share one stimulus stream; each scenario checks the instance it targets.
module tb_udc_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, up, load, clr;
    logic [3:0] din;
    logic [3:0] a_out, b_out;
    logic [2:0] c_out;
    logic       a_tc, a_ovf, b_tc, b_ovf, c_tc, c_ovf;

    always #5 clk = ~clk;

    udc_param #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1'b0)) u_a (
        .udc_clk(clk), .udc_rst(rst_n), .udc_en(en), .udc_up(up), .udc_load(load),
        .udc_din(din), .udc_clr_ovf(clr), .udc_out(a_out), .udc_tc(a_tc), .udc_ovf(a_ovf));

    udc_param #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1'b1)) u_b (
        .udc_clk(clk), .udc_rst(rst_n), .udc_en(en), .udc_up(up), .udc_load(load),
        .udc_din(din), .udc_clr_ovf(clr), .udc_out(b_out), .udc_tc(b_tc), .udc_ovf(b_ovf));

    udc_param #(.WIDTH(3), .MODULUS(64'd8), .SATURATE(1'b0)) u_c (
        .udc_clk(clk), .udc_rst(rst_n), .udc_en(en), .udc_up(up), .udc_load(load),
        .udc_din(din[2:0]), .udc_clr_ovf(clr), .udc_out(c_out), .udc_tc(c_tc), .udc_ovf(c_ovf));

    typedef struct packed {
        logic       l;
        logic [3:0] d;
        logic       e;
        logic       u;
        logic       c;
        logic [3:0] o;
        logic       t;
        logic       v;
    } step_t;

    typedef struct {
        int         sel;
        logic [5:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    function automatic logic [5:0] observe(input int sel);
        case (sel)
            0:       return {a_out, a_tc, a_ovf};
            1:       return {b_out, b_tc, b_ovf};
            default: return {1'b0, c_out, c_tc, c_ovf};
        endcase
    endfunction

    // Drive one step's inputs and push its expected result for the selected instance.
    task automatic apply(input int sel, input step_t s);
        sb_t item;
        load = s.l; din = s.d; en = s.e; up = s.u; clr = s.c;
        item.sel = sel;
        item.exp = {s.o, s.t, s.v};
        sb_q.push_back(item);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        rst_n = 1'b0;
        load = 1'b0; din = 4'd0; en = 1'b0; up = 1'b0; clr = 1'b0;
        #12;
        for (int k = 0; k < 3; k++) begin
            got = observe(k);
            n_cmp++;
            if (got !== 6'd0) begin
                n_err++;
                $display("FAIL reset_state inst%0d: got out=%0d tc=%b ovf=%b, want 0/0/0", k, got[5:2], got[1], got[0]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_up_wrap();
        step_t tbl [4] = '{
            '{1'b1, 4'd8, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0},
            '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0},
            '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1},
            '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1}};
        sb_t        e;
        logic [5:0] got;
        for (int i = 0; i < 4; i++) begin
            apply(0, tbl[i]);
            tick();
            e = sb_q.pop_front();
            got = observe(e.sel);
            n_cmp++;
            if (got !== e.exp) begin
                n_err++;
                $display("FAIL up_wrap step%0d: got out=%0d tc=%b ovf=%b, want out=%0d tc=%b ovf=%b",
                         i, got[5:2], got[1], got[0], e.exp[5:2], e.exp[1], e.exp[0]);
            end
        end
    endtask

    task automatic test_down_wrap_clear();
        step_t tbl [5] = '{
            '{1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0},
            '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0},
            '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd9, 1'b1, 1'b1},
            '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0},
            '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0}};
        sb_t        e;
        logic [5:0] got;
        for (int i = 0; i < 5; i++) begin
            apply(0, tbl[i]);
            tick();
            e = sb_q.pop_front();
            got = observe(e.sel);
            n_cmp++;
            if (got !== e.exp) begin
                n_err++;
                $display("FAIL down_wrap_clear step%0d: got out=%0d tc=%b ovf=%b, want out=%0d tc=%b ovf=%b",
                         i, got[5:2], got[1], got[0], e.exp[5:2], e.exp[1], e.exp[0]);
            end
        end
    endtask

    task automatic test_saturate();
        step_t tbl [6] = '{
            '{1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0},
            '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd9, 1'b1, 1'b1},
            '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd9, 1'b1, 1'b1},
            '{1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1},
            '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1},
            '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1}};
        sb_t        e;
        logic [5:0] got;
        for (int i = 0; i < 6; i++) begin
            apply(1, tbl[i]);
            tick();
            e = sb_q.pop_front();
            got = observe(e.sel);
            n_cmp++;
            if (got !== e.exp) begin
                n_err++;
                $display("FAIL saturate step%0d: got out=%0d tc=%b ovf=%b, want out=%0d tc=%b ovf=%b",
                         i, got[5:2], got[1], got[0], e.exp[5:2], e.exp[1], e.exp[0]);
            end
        end
    endtask

    task automatic test_load_clamp();
        step_t tbl [4] = '{
            '{1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0},
            '{1'b1, 4'd13, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0},
            '{1'b1, 4'd9,  1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0},
            '{1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0}};
        sb_t        e;
        logic [5:0] got;
        for (int i = 0; i < 4; i++) begin
            apply(0, tbl[i]);
            tick();
            e = sb_q.pop_front();
            got = observe(e.sel);
            n_cmp++;
            if (got !== e.exp) begin
                n_err++;
                $display("FAIL load_clamp step%0d: got out=%0d tc=%b ovf=%b, want out=%0d tc=%b ovf=%b",
                         i, got[5:2], got[1], got[0], e.exp[5:2], e.exp[1], e.exp[0]);
            end
        end
    endtask

    task automatic test_set_over_clear();
        step_t tbl [3] = '{
            '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1},
            '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b1, 1'b1},
            '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0}};
        sb_t        e;
        logic [5:0] got;
        for (int i = 0; i < 3; i++) begin
            apply(0, tbl[i]);
            tick();
            e = sb_q.pop_front();
            got = observe(e.sel);
            n_cmp++;
            if (got !== e.exp) begin
                n_err++;
                $display("FAIL set_over_clear step%0d: got out=%0d tc=%b ovf=%b, want out=%0d tc=%b ovf=%b",
                         i, got[5:2], got[1], got[0], e.exp[5:2], e.exp[1], e.exp[0]);
            end
        end
    endtask

    task automatic test_full_range();
        step_t tbl [5] = '{
            '{1'b1, 4'd7, 1'b0, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0},
            '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1},
            '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 1'b1},
            '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd6, 1'b0, 1'b1},
            '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd7, 1'b0, 1'b1}};
        sb_t        e;
        logic [5:0] got;
        for (int i = 0; i < 5; i++) begin
            apply(2, tbl[i]);
            tick();
            e = sb_q.pop_front();
            got = observe(e.sel);
            n_cmp++;
            if (got !== e.exp) begin
                n_err++;
                $display("FAIL full_range step%0d: got out=%0d tc=%b ovf=%b, want out=%0d tc=%b ovf=%b",
                         i, got[5:2], got[1], got[0], e.exp[5:2], e.exp[1], e.exp[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        step_t tbl [4] = '{
            '{1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0},
            '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1},
            '{1'b1, 4'd6, 1'b0, 1'b1, 1'b0, 4'd6, 1'b0, 1'b0},
            '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0}};
        sb_t        e;
        logic [5:0] got;
        for (int i = 0; i < 4; i++) begin
            apply(0, tbl[i]);
            tick();
            e = sb_q.pop_front();
            got = observe(e.sel);
            n_cmp++;
            if (got !== e.exp) begin
                n_err++;
                $display("FAIL reset_mid_setup step%0d: got out=%0d tc=%b ovf=%b, want out=%0d tc=%b ovf=%b",
                         i, got[5:2], got[1], got[0], e.exp[5:2], e.exp[1], e.exp[0]);
            end
            if (i == 1 || i == 3) begin
                #2;
                rst_n = 1'b0;
                #1;
                for (int k = 0; k < 3; k++) begin
                    got = observe(k);
                    n_cmp++;
                    if (got !== 6'd0) begin
                        n_err++;
                        $display("FAIL reset_async step%0d inst%0d: got out=%0d tc=%b ovf=%b, want 0/0/0",
                                 i, k, got[5:2], got[1], got[0]);
                    end
                end
                tick();
                tick();
                got = observe(0);
                n_cmp++;
                if (got !== 6'd0) begin
                    n_err++;
                    $display("FAIL reset_held step%0d: got out=%0d tc=%b ovf=%b, want 0/0/0",
                             i, got[5:2], got[1], got[0]);
                end
                rst_n = 1'b1;
            end
        end
        load = 1'b0; en = 1'b0; clr = 1'b0;
        tick();
        got = observe(0);
        n_cmp++;
        if (got !== 6'd0) begin
            n_err++;
            $display("FAIL reset_release_hold: got out=%0d tc=%b ovf=%b, want 0/0/0", got[5:2], got[1], got[0]);
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap_clear();
        test_saturate();
        test_load_clamp();
        test_set_over_clear();
        test_full_range();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
